// File: rtl/jump_resolve.sv
// Jump resolution stage: registered redirect/flush for taken control transfers,
// plus a small circular queue that carries link values to rd writeback.
module jump_resolve #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32,
    parameter int RD_W  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fu_finish,
    input  logic [XLEN-1:0] fu_pc_jump,
    input  logic [XLEN-1:0] fu_pc_wb,
    input  logic            fu_cmp_res,
    input  logic            op_branch,
    input  logic            op_jalr,
    input  logic [RD_W-1:0] rd_in,
    input  logic            rd_we_in,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic            misalign_exc,
    output logic            wb_valid,
    output logic [RD_W-1:0] wb_rd,
    output logic [XLEN-1:0] wb_data,
    input  logic            wb_ready,
    output logic            busy,
    output logic            overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic            taken;
    logic [XLEN-1:0] target;

    logic            redir_q, redir_d;
    logic            misal_q, misal_d;
    logic [XLEN-1:0] rpc_q, rpc_d;

    logic [RD_W-1:0] rd_mem_q   [DEPTH];
    logic [XLEN-1:0] data_mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;

    logic            full;
    logic            push_req;
    logic            push;
    logic            pop;

    assign taken  = op_branch ? fu_cmp_res : 1'b1;
    assign target = op_jalr ? {fu_pc_jump[XLEN-1:1], 1'b0} : fu_pc_jump;

    // Redirect side: targets with bit 1 set trap instead of redirecting.
    always_comb begin
        redir_d = 1'b0;
        misal_d = 1'b0;
        rpc_d   = rpc_q;
        if (fu_finish && taken) begin
            if (target[1]) begin
                misal_d = 1'b1;
            end else begin
                redir_d = 1'b1;
                rpc_d   = target;
            end
        end
    end

    assign full     = (count_q == FULL);
    assign wb_valid = (count_q != '0);
    assign pop      = wb_valid & wb_ready;
    assign push_req = fu_finish & rd_we_in & (rd_in != '0);
    // A pop in the same cycle frees the slot, so a full queue can still accept.
    assign push     = push_req & (~full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (push_req & full & ~pop);
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            redir_q  <= 1'b0;
            misal_q  <= 1'b0;
            rpc_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
            end
        end else begin
            redir_q  <= redir_d;
            misal_q  <= misal_d;
            rpc_q    <= rpc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            if (push) begin
                rd_mem_q[wr_ptr_q]   <= rd_in;
                data_mem_q[wr_ptr_q] <= fu_pc_wb;
            end
        end
    end

    assign redirect_valid = redir_q;
    assign flush          = redir_q;
    assign redirect_pc    = rpc_q;
    assign misalign_exc   = misal_q;
    assign wb_rd          = rd_mem_q[rd_ptr_q];
    assign wb_data        = data_mem_q[rd_ptr_q];
    assign busy           = full;
    assign overflow       = ovf_q;

endmodule

// File: tb/tb_jump_resolve.sv
// Bench for jump_resolve: queue/redirect reference model compared every cycle,
// plus directed vectors with literal expectations.
module tb_jump_resolve;

    localparam int DEPTH = 2;
    localparam int XLEN  = 32;
    localparam int RD_W  = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            fu_finish;
    logic [XLEN-1:0] fu_pc_jump;
    logic [XLEN-1:0] fu_pc_wb;
    logic            fu_cmp_res;
    logic            op_branch;
    logic            op_jalr;
    logic [RD_W-1:0] rd_in;
    logic            rd_we_in;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;
    logic            misalign_exc;
    logic            wb_valid;
    logic [RD_W-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            wb_ready;
    logic            busy;
    logic            overflow;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    jump_resolve #(.DEPTH(DEPTH), .XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk(clk), .rst(rst),
        .fu_finish(fu_finish), .fu_pc_jump(fu_pc_jump), .fu_pc_wb(fu_pc_wb),
        .fu_cmp_res(fu_cmp_res), .op_branch(op_branch), .op_jalr(op_jalr),
        .rd_in(rd_in), .rd_we_in(rd_we_in),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush(flush), .misalign_exc(misalign_exc),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_ready(wb_ready), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: queue of {rd, link} plus expected redirect state.
    logic [RD_W+XLEN-1:0] mq[$];
    bit                   m_rv, m_mis, m_ovf;
    logic [XLEN-1:0]      m_pc;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_rv  = 0;
            m_mis = 0;
            m_ovf = 0;
            m_pc  = '0;
        end else begin
            logic [XLEN-1:0] tgt;
            bit tk, want, pop;
            tk   = op_branch ? fu_cmp_res : 1'b1;
            tgt  = fu_pc_jump;
            if (op_jalr) tgt[0] = 1'b0;
            m_rv  = 0;
            m_mis = 0;
            if (fu_finish && tk) begin
                if (tgt[1]) m_mis = 1;
                else begin
                    m_rv = 1;
                    m_pc = tgt;
                end
            end
            pop  = (mq.size() > 0) && wb_ready;
            want = fu_finish && rd_we_in && (rd_in != 0);
            if (pop) void'(mq.pop_front());
            if (want) begin
                if (mq.size() < DEPTH) mq.push_back({rd_in, fu_pc_wb});
                else m_ovf = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("m_redirect_valid", 64'(redirect_valid), 64'(m_rv));
            chk("m_flush", 64'(flush), 64'(m_rv));
            chk("m_misalign", 64'(misalign_exc), 64'(m_mis));
            chk("m_redirect_pc", 64'(redirect_pc), 64'(m_pc));
            chk("m_wb_valid", 64'(wb_valid), 64'(mq.size() != 0));
            chk("m_busy", 64'(busy), 64'(mq.size() == DEPTH));
            chk("m_overflow", 64'(overflow), 64'(m_ovf));
            if (mq.size() != 0) begin
                chk("m_wb_rd", 64'(wb_rd), 64'(mq[0][RD_W+XLEN-1:XLEN]));
                chk("m_wb_data", 64'(wb_data), 64'(mq[0][XLEN-1:0]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit br, input bit jr, input bit cmp,
                         input logic [XLEN-1:0] pj, input logic [XLEN-1:0] pw,
                         input logic [RD_W-1:0] rd, input bit we);
        fu_finish  = 1'b1;
        op_branch  = br;
        op_jalr    = jr;
        fu_cmp_res = cmp;
        fu_pc_jump = pj;
        fu_pc_wb   = pw;
        rd_in      = rd;
        rd_we_in   = we;
        step();
        fu_finish  = 1'b0;
        op_branch  = 1'b0;
        op_jalr    = 1'b0;
        fu_cmp_res = 1'b0;
        rd_we_in   = 1'b0;
    endtask

    task automatic all_zero(string tag);
        chk({tag, "_rv"}, 64'(redirect_valid), 64'd0);
        chk({tag, "_flush"}, 64'(flush), 64'd0);
        chk({tag, "_pc"}, 64'(redirect_pc), 64'd0);
        chk({tag, "_mis"}, 64'(misalign_exc), 64'd0);
        chk({tag, "_wbv"}, 64'(wb_valid), 64'd0);
        chk({tag, "_wbrd"}, 64'(wb_rd), 64'd0);
        chk({tag, "_wbdata"}, 64'(wb_data), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_ovf"}, 64'(overflow), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        fu_finish = 0; fu_pc_jump = '0; fu_pc_wb = '0; fu_cmp_res = 0;
        op_branch = 0; op_jalr = 0; rd_in = '0; rd_we_in = 0; wb_ready = 0;
        step();
        step();
        all_zero("reset");
        rst = 1'b0;
        chk_en = 1;

        // 1) BEQ taken
        issue(1, 0, 1, 32'h100, 32'h4, 5'd0, 0);
        chk("beq_rv", 64'(redirect_valid), 64'd1);
        chk("beq_flush", 64'(flush), 64'd1);
        chk("beq_pc", 64'(redirect_pc), 64'h100);
        chk("beq_wbv", 64'(wb_valid), 64'd0);
        step();
        chk("beq_pulse_end", 64'(redirect_valid), 64'd0);

        // 2) BNE not taken
        issue(1, 0, 0, 32'h300, 32'h8, 5'd5, 0);
        chk("bne_rv", 64'(redirect_valid), 64'd0);
        chk("bne_pc_hold", 64'(redirect_pc), 64'h100);
        chk("bne_wbv", 64'(wb_valid), 64'd0);

        // 3) JALR with link writeback held until ready
        issue(0, 1, 0, 32'h205, 32'h44, 5'd1, 1);
        chk("jalr_rv", 64'(redirect_valid), 64'd1);
        chk("jalr_pc", 64'(redirect_pc), 64'h204);
        chk("jalr_wbv", 64'(wb_valid), 64'd1);
        chk("jalr_wbrd", 64'(wb_rd), 64'd1);
        chk("jalr_wbdata", 64'(wb_data), 64'h44);
        step();
        step();
        chk("jalr_hold", 64'(wb_valid), 64'd1);
        wb_ready = 1;
        step();
        wb_ready = 0;
        chk("jalr_popped", 64'(wb_valid), 64'd0);

        // 4) JAL to x0, then misaligned JALR
        issue(0, 0, 0, 32'h400, 32'h50, 5'd0, 1);
        chk("jal_x0_rv", 64'(redirect_valid), 64'd1);
        chk("jal_x0_wbv", 64'(wb_valid), 64'd0);
        issue(0, 1, 0, 32'h103, 32'h88, 5'd7, 1);
        chk("mis_exc", 64'(misalign_exc), 64'd1);
        chk("mis_rv", 64'(redirect_valid), 64'd0);
        chk("mis_pc_hold", 64'(redirect_pc), 64'h400);
        chk("mis_wbdata", 64'(wb_data), 64'h88);
        step();
        chk("mis_pulse_end", 64'(misalign_exc), 64'd0);
        wb_ready = 1;
        step();
        wb_ready = 0;

        // 5) fill, overflow, push+pop while full, in-order drain across wrap
        issue(0, 0, 0, 32'h500, 32'h10, 5'd1, 1);
        chk("fill1_busy", 64'(busy), 64'd0);
        issue(0, 0, 0, 32'h504, 32'h20, 5'd2, 1);
        chk("fill2_busy", 64'(busy), 64'd1);
        issue(0, 0, 0, 32'h508, 32'h30, 5'd3, 1);
        chk("fill3_ovf", 64'(overflow), 64'd1);
        chk("fill3_head", 64'(wb_rd), 64'd1);
        wb_ready = 1;
        issue(0, 0, 0, 32'h50c, 32'h40, 5'd4, 1);
        chk("pp_busy", 64'(busy), 64'd1);
        chk("pp_head_rd", 64'(wb_rd), 64'd2);
        chk("pp_head_data", 64'(wb_data), 64'h20);
        step();
        chk("drain_rd4", 64'(wb_rd), 64'd4);
        chk("drain_data4", 64'(wb_data), 64'h40);
        step();
        chk("drain_empty", 64'(wb_valid), 64'd0);
        chk("ovf_sticky", 64'(overflow), 64'd1);
        wb_ready = 0;

        // 6) reset with a full queue and a redirect in flight
        issue(0, 0, 0, 32'h600, 32'h60, 5'd9, 1);
        issue(0, 0, 0, 32'h604, 32'h64, 5'd10, 1);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        fu_finish = 1; fu_pc_jump = 32'h700; fu_pc_wb = 32'h70;
        rd_in = 5'd11; rd_we_in = 1;
        step();
        fu_finish = 0; rd_we_in = 0;
        all_zero("midrst");
        rst = 1'b0;
        step();
        chk("post_rst_rv", 64'(redirect_valid), 64'd0);
        chk("post_rst_wbv", 64'(wb_valid), 64'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
